vrf_seq_ctrl: RTL and testbench

VRF_SEQ_CTRL -- requirements
Module: vrf_seq_ctrl

---
 rtl/vrf_seq_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_vrf_seq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_seq_ctrl.sv
// Vector register-file sequencer: steps a command element by element through
// READ/EXEC/WRITE and interleaves single-element host accesses in IDLE/EXEC.
module vrf_seq_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REG    = 6,
  parameter int NUM_ELE    = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_vd,
  input  logic [ADDR_WIDTH-1:0] cmd_vs1,
  input  logic [ADDR_WIDTH-1:0] cmd_vs2,
  input  logic [ADDR_WIDTH:0]   cmd_vl,

  output logic                  exu_valid,
  output logic [DATA_WIDTH-1:0] exu_a,
  output logic [DATA_WIDTH-1:0] exu_b,
  input  logic                  exu_res_valid,
  input  logic [DATA_WIDTH-1:0] exu_res,

  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_reg,
  input  logic [ADDR_WIDTH-1:0] host_ele,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,

  output logic [ADDR_WIDTH-1:0] rf_rAddr1_1,
  output logic [ADDR_WIDTH-1:0] rf_rAddr2_1,
  output logic [ADDR_WIDTH-1:0] rf_rAddr1_2,
  output logic [ADDR_WIDTH-1:0] rf_rAddr2_2,
  input  logic [DATA_WIDTH-1:0] rf_rData1,
  input  logic [DATA_WIDTH-1:0] rf_rData2,
  output logic [ADDR_WIDTH-1:0] rf_wAddr1,
  output logic [ADDR_WIDTH-1:0] rf_wAddr2,
  output logic [DATA_WIDTH-1:0] rf_wData,
  output logic                  rf_wEnable,

  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err
);

  localparam logic [ADDR_WIDTH:0] LP_NREG = (ADDR_WIDTH+1)'(NUM_REG);
  localparam logic [ADDR_WIDTH:0] LP_NELE = (ADDR_WIDTH+1)'(NUM_ELE);
  localparam logic [ADDR_WIDTH:0] LP_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_vd;
  logic [ADDR_WIDTH-1:0] r_vs1;
  logic [ADDR_WIDTH-1:0] r_vs2;
  logic [ADDR_WIDTH-1:0] r_e;
  logic [ADDR_WIDTH:0]   r_vl;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [DATA_WIDTH-1:0] r_res;
  logic [DATA_WIDTH-1:0] r_host_rdata;
  logic                  r_host_rvalid;
  logic                  r_cmd_err;

  logic                  w_accept;
  logic                  w_cmd_bad;
  logic [ADDR_WIDTH:0]   w_vl_clamp;
  logic                  w_last;
  logic                  w_host_gnt;
  logic                  w_host_ok;
  logic                  w_host_wr;
  logic                  w_host_rd;

  assign w_accept   = cmd_valid & cmd_ready;
  assign w_cmd_bad  = ({1'b0, cmd_vd}  >= LP_NREG) |
                      ({1'b0, cmd_vs1} >= LP_NREG) |
                      ({1'b0, cmd_vs2} >= LP_NREG);
  assign w_vl_clamp = (cmd_vl > LP_NELE) ? LP_NELE : cmd_vl;
  assign w_last     = ({1'b0, r_e} == (r_vl - LP_ONE));

  // Host is only serviced while the sequencer does not own the regfile ports.
  assign w_host_gnt = host_req & ~reset & ((r_state == S_IDLE) | (r_state == S_EXEC));
  assign w_host_ok  = ({1'b0, host_reg} < LP_NREG) & ({1'b0, host_ele} < LP_NELE);
  assign w_host_wr  = w_host_gnt & host_we & w_host_ok;
  assign w_host_rd  = w_host_gnt & ~host_we & w_host_ok;

  assign host_gnt    = w_host_gnt;
  assign host_rvalid = r_host_rvalid;
  assign host_rdata  = r_host_rdata;
  assign cmd_err     = r_cmd_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    cmd_ready   = 1'b0;
    exu_valid   = 1'b0;
    exu_a       = '0;
    exu_b       = '0;
    rf_rAddr1_1 = '0;
    rf_rAddr2_1 = '0;
    rf_rAddr1_2 = '0;
    rf_rAddr2_2 = '0;
    rf_wAddr1   = '0;
    rf_wAddr2   = '0;
    rf_wData    = '0;
    rf_wEnable  = 1'b0;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        cmd_ready = ~host_req;
        if (w_accept && !w_cmd_bad) begin
          w_next = (w_vl_clamp == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        rf_rAddr1_1 = r_vs1;
        rf_rAddr2_1 = r_e;
        rf_rAddr1_2 = r_vs2;
        rf_rAddr2_2 = r_e;
        w_next      = S_EXEC;
      end
      S_EXEC: begin
        exu_valid = 1'b1;
        exu_a     = r_op_a;
        exu_b     = r_op_b;
        if (exu_res_valid) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        rf_wEnable = 1'b1;
        rf_wAddr1  = r_vd;
        rf_wAddr2  = r_e;
        rf_wData   = r_res;
        w_next     = w_last ? S_DONE : S_READ;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Grants only occur in IDLE/EXEC, so these never collide with READ/WRITE.
    if (w_host_wr) begin
      rf_wEnable = 1'b1;
      rf_wAddr1  = host_reg;
      rf_wAddr2  = host_ele;
      rf_wData   = host_wdata;
    end
    if (w_host_rd) begin
      rf_rAddr1_1 = host_reg;
      rf_rAddr2_1 = host_ele;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vd          <= '0;
      r_vs1         <= '0;
      r_vs2         <= '0;
      r_vl          <= '0;
      r_e           <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_res         <= '0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_cmd_err     <= w_accept & w_cmd_bad;
      r_host_rvalid <= w_host_gnt & ~host_we;
      r_host_rdata  <= w_host_rd ? rf_rData1 : '0;

      if (w_accept && !w_cmd_bad) begin
        r_vd  <= cmd_vd;
        r_vs1 <= cmd_vs1;
        r_vs2 <= cmd_vs2;
        r_vl  <= w_vl_clamp;
        r_e   <= '0;
      end

      if (r_state == S_READ) begin
        r_op_a <= rf_rData1;
        r_op_b <= rf_rData2;
      end

      if ((r_state == S_EXEC) && exu_res_valid) begin
        r_res <= exu_res;
      end

      if ((r_state == S_WRITE) && !w_last) begin
        r_e <= r_e + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_vrf_seq_ctrl.sv
// Bench for vrf_seq_ctrl: behavioural regfile + exu environment, element-wise
// reference model of each command, directed corner cases and random commands.
module tb_vrf_seq_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 6;
  localparam int NE = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_vd, cmd_vs1, cmd_vs2;
  logic [AW:0]   cmd_vl;
  logic          exu_valid;
  logic [DW-1:0] exu_a, exu_b;
  logic          exu_res_valid;
  logic [DW-1:0] exu_res;
  logic          host_req, host_we;
  logic [AW-1:0] host_reg, host_ele;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] rf_rAddr1_1, rf_rAddr2_1, rf_rAddr1_2, rf_rAddr2_2;
  logic [DW-1:0] rf_rData1, rf_rData2;
  logic [AW-1:0] rf_wAddr1, rf_wAddr2;
  logic [DW-1:0] rf_wData;
  logic          rf_wEnable;
  logic          busy, done, cmd_err;

  always #5 clk = ~clk;

  vrf_seq_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REG(NR), .NUM_ELE(NE)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vl(cmd_vl),
    .exu_valid(exu_valid), .exu_a(exu_a), .exu_b(exu_b),
    .exu_res_valid(exu_res_valid), .exu_res(exu_res),
    .host_req(host_req), .host_we(host_we), .host_reg(host_reg), .host_ele(host_ele),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .rf_rAddr1_1(rf_rAddr1_1), .rf_rAddr2_1(rf_rAddr2_1),
    .rf_rAddr1_2(rf_rAddr1_2), .rf_rAddr2_2(rf_rAddr2_2),
    .rf_rData1(rf_rData1), .rf_rData2(rf_rData2),
    .rf_wAddr1(rf_wAddr1), .rf_wAddr2(rf_wAddr2), .rf_wData(rf_wData),
    .rf_wEnable(rf_wEnable),
    .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  // Environment regfile (written only by the DUT) and reference contents.
  logic [DW-1:0] mem     [NR][NE];
  logic [DW-1:0] ref_mem [NR][NE];

  typedef struct {
    int            r;
    int            e;
    logic [DW-1:0] d;
  } wr_t;
  wr_t wlog[$];

  assign rf_rData1 = (int'(rf_rAddr1_1) < NR) ? mem[rf_rAddr1_1][rf_rAddr2_1] : '0;
  assign rf_rData2 = (int'(rf_rAddr1_2) < NR) ? mem[rf_rAddr1_2][rf_rAddr2_2] : '0;

  initial begin
    forever begin
      @(posedge clk);
      if (rf_wEnable === 1'b1) begin
        wlog.push_back('{int'(rf_wAddr1), int'(rf_wAddr2), rf_wData});
        if (int'(rf_wAddr1) < NR) mem[rf_wAddr1][rf_wAddr2] <= rf_wData;
      end
    end
  end

  // Execution unit: adds operands after cur_wait extra cycles; noise elsewhere.
  int cur_wait;
  int exu_cnt;
  initial begin
    exu_res_valid = 1'b0;
    exu_res       = '0;
    exu_cnt       = 0;
    forever begin
      @(negedge clk);
      if (exu_valid) begin
        if (exu_cnt >= cur_wait) begin
          exu_res_valid = 1'b1;
          exu_res       = exu_a + exu_b;
          exu_cnt       = 0;
        end else begin
          exu_res_valid = 1'b0;
          exu_res       = $urandom;
          exu_cnt++;
        end
      end else begin
        exu_res_valid = 1'($urandom_range(0, 1));
        exu_res       = $urandom;
        exu_cnt       = 0;
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int mem_diff();
    int d = 0;
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < NE; e++)
        if (mem[r][e] !== ref_mem[r][e]) d++;
    return d;
  endfunction

  task automatic host_write(input int r, input int e, input logic [DW-1:0] d);
    bit inr;
    inr        = (r < NR) && (e < NE);
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_reg   = AW'(r);
    host_ele   = AW'(e);
    host_wdata = d;
    #1;
    chk("hw_gnt", 64'(host_gnt), 64'(1));
    chk("hw_wen", 64'(rf_wEnable), 64'(inr));
    @(posedge clk); #1;
    host_req = 1'b0;
    host_we  = 1'b0;
    if (inr) ref_mem[r][e] = d;
  endtask

  task automatic host_read(input int r, input int e, input logic [DW-1:0] exp);
    host_req = 1'b1;
    host_we  = 1'b0;
    host_reg = AW'(r);
    host_ele = AW'(e);
    #1;
    chk("hr_gnt", 64'(host_gnt), 64'(1));
    @(posedge clk); #1;
    host_req = 1'b0;
    chk("hr_rvalid", 64'(host_rvalid), 64'(1));
    chk("hr_rdata", 64'(host_rdata), 64'(exp));
    @(posedge clk); #1;
    chk("hr_rvalid_lo", 64'(host_rvalid), 64'(0));
  endtask

  // One command from acceptance to completion; hx issues a host read in EXEC,
  // rmid asserts reset in EXEC of element 1.
  task automatic run_cmd(input int vd, input int vs1, input int vs2, input int vl,
                         input int w, input bit hx, input bit rmid);
    int            n, k, exu_cyc, exp_lat, bad_cnt, lim, dcnt, hr_reg, hr_ele;
    bit            bad, hr_pend, hr_done;
    logic [DW-1:0] hr_exp;
    logic [DW-1:0] expv [NE];
    bad = (vd >= NR) || (vs1 >= NR) || (vs2 >= NR);
    n   = (vl > NE) ? NE : vl;
    if (!bad)
      for (int i = 0; i < n; i++) expv[i] = ref_mem[vs1][i] + ref_mem[vs2][i];
    exp_lat  = n * (3 + w) + 1;
    cur_wait = w;
    wlog.delete();

    cmd_vd    = AW'(vd);
    cmd_vs1   = AW'(vs1);
    cmd_vs2   = AW'(vs2);
    cmd_vl    = (AW+1)'(vl);
    cmd_valid = 1'b1;
    #1;
    chk("cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    if (bad) begin
      chk("err_pulse", 64'(cmd_err), 64'(1));
      chk("err_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
      chk("err_pulse_end", 64'(cmd_err), 64'(0));
      chk("err_busy2", 64'(busy), 64'(0));
      chk("err_nowrite", 64'(wlog.size()), 64'(0));
      return;
    end
    chk("cmd_err_lo", 64'(cmd_err), 64'(0));

    k = 1; exu_cyc = 0; hr_pend = 1'b0; hr_done = 1'b0;
    while (!done && k < 3000) begin
      if (hr_pend) begin
        host_req = 1'b0;
        chk("hx_rvalid", 64'(host_rvalid), 64'(1));
        chk("hx_rdata", 64'(host_rdata), 64'(hr_exp));
        hr_pend = 1'b0;
      end
      if (exu_valid) exu_cyc++;
      if (rmid && exu_valid && wlog.size() == 1) begin
        reset = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_exu", 64'(exu_valid), 64'(0));
        chk("rst_wen", 64'(rf_wEnable), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        dcnt  = 0;
        for (int c = 0; c < 4; c++) begin
          if (done) dcnt++;
          @(posedge clk); #1;
        end
        chk("rst_nodone", 64'(dcnt), 64'(0));
        chk("rst_writes", 64'(wlog.size()), 64'(1));
        ref_mem[vd][0] = expv[0];
        chk("rst_mem", 64'(mem_diff()), 64'(0));
        return;
      end
      if (hx && !hr_done && exu_valid) begin
        hr_reg   = (vd + 1) % NR;
        hr_ele   = $urandom_range(0, NE - 1);
        hr_exp   = ref_mem[hr_reg][hr_ele];
        host_req = 1'b1;
        host_we  = 1'b0;
        host_reg = AW'(hr_reg);
        host_ele = AW'(hr_ele);
        #1;
        chk("hx_gnt", 64'(host_gnt), 64'(1));
        hr_pend = 1'b1;
        hr_done = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    host_req = 1'b0;
    chk("done_seen", 64'(done), 64'(1));
    chk("latency", 64'(k), 64'(exp_lat));
    chk("exu_cycles", 64'(exu_cyc), 64'(n * (w + 1)));
    if (hx) chk("hx_issued", 64'(hr_done), 64'(1));
    chk("wr_count", 64'(wlog.size()), 64'(n));
    bad_cnt = 0;
    lim = (wlog.size() < n) ? wlog.size() : n;
    for (int i = 0; i < lim; i++)
      if (wlog[i].r != vd || wlog[i].e != i || wlog[i].d !== expv[i]) bad_cnt++;
    chk("wr_content", 64'(bad_cnt), 64'(0));
    for (int i = 0; i < n; i++) ref_mem[vd][i] = expv[i];
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'(0));
    chk("busy_end", 64'(busy), 64'(0));
    chk("mem", 64'(mem_diff()), 64'(0));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int vd, vs1, vs2, vl, w;
    bit hx;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_vd     = '0;
    cmd_vs1    = '0;
    cmd_vs2    = '0;
    cmd_vl     = '0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_reg   = '0;
    host_ele   = '0;
    host_wdata = '0;
    cur_wait   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy0", 64'(busy), 64'(0));
    chk("rst_done0", 64'(done), 64'(0));
    chk("rst_exu0", 64'(exu_valid), 64'(0));
    chk("rst_wen0", 64'(rf_wEnable), 64'(0));
    chk("rst_cmd_err0", 64'(cmd_err), 64'(0));
    chk("rst_rvalid0", 64'(host_rvalid), 64'(0));
    chk("rst_cmd_ready0", 64'(cmd_ready), 64'(1));
    chk("rst_addr0", 64'({rf_rAddr1_1, rf_rAddr2_1, rf_rAddr1_2, rf_rAddr2_2, rf_wAddr1, rf_wAddr2}), 64'(0));
    host_req = 1'b1;
    #1;
    chk("rst_cmd_ready_hreq", 64'(cmd_ready), 64'(0));
    chk("rst_gnt0", 64'(host_gnt), 64'(0));
    host_req = 1'b0;
    reset    = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < NR; r++)
      for (int e = 0; e < NE; e++) host_write(r, e, $urandom);
    chk("preload", 64'(mem_diff()), 64'(0));

    host_write(7, 3, 32'hDEAD_BEEF);
    host_read(6, 0, '0);
    host_read(2, 5, ref_mem[2][5]);

    run_cmd(2, 0, 1, 4, 0, 1'b0, 1'b0);
    run_cmd(3, 1, 2, 2, 3, 1'b1, 1'b0);

    // Host and command offered together: host wins, command goes next cycle.
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_reg  = AW'(0);
    host_ele  = AW'(7);
    cmd_vd    = AW'(5);
    cmd_vs1   = AW'(0);
    cmd_vs2   = AW'(1);
    cmd_vl    = (AW+1)'(3);
    cmd_valid = 1'b1;
    #1;
    chk("pri_gnt", 64'(host_gnt), 64'(1));
    chk("pri_cmd_ready", 64'(cmd_ready), 64'(0));
    @(posedge clk); #1;
    host_req = 1'b0;
    chk("pri_rvalid", 64'(host_rvalid), 64'(1));
    chk("pri_rdata", 64'(host_rdata), 64'(ref_mem[0][7]));
    chk("pri_not_busy", 64'(busy), 64'(0));
    run_cmd(5, 0, 1, 3, 1, 1'b0, 1'b0);

    run_cmd(4, 0, 0, 0, 1, 1'b0, 1'b0);
    run_cmd(6, 0, 1, 4, 0, 1'b0, 1'b0);
    run_cmd(1, 7, 0, 3, 0, 1'b0, 1'b0);
    run_cmd(5, 3, 4, 40, 0, 1'b0, 1'b0);
    run_cmd(0, 2, 3, 4, 2, 1'b0, 1'b1);
    run_cmd(0, 2, 3, 4, 1, 1'b0, 1'b0);
    run_cmd(1, 1, 1, 5, 2, 1'b1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      vd  = $urandom_range(0, NR);
      vs1 = $urandom_range(0, NR - 1);
      vs2 = $urandom_range(0, NR - 1);
      vl  = $urandom_range(0, 40);
      w   = $urandom_range(0, 3);
      hx  = (vl > 0) && ($urandom_range(0, 1) == 1);
      run_cmd(vd, vs1, vs2, vl, w, hx, 1'b0);
    end

    for (int t = 0; t < 4; t++) begin
      vd  = $urandom_range(0, NR - 1);
      vl  = $urandom_range(0, NE - 1);
      host_read(vd, vl, ref_mem[vd][vl]);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
